rgb_pwm_driver: RTL

- Consumes the 24-bit RGB code from the light selector stage (R=[23:16], G=[15:8], B=[7:0]) and drives three physical LED pins with 8-bit PWM.
- Applies a global brightness scale.
- Duty values are double-buffered: the new colour and brightness take effect only at a PWM frame boundary, so there is no glitching mid-frame.
- Sits directly downstream of the selector's light output, at the board top level.

---
 rtl/rgb_pwm_driver.sv | 77 +++++++
 1 files changed

// File: rtl/rgb_pwm_driver.sv
// rtl/rgb_pwm_driver.sv - 8-bit RGB PWM LED driver with global brightness and frame-aligned duty updates
module rgb_pwm_driver #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [23:0] light,
  input  logic [7:0]  brightness,
  output logic        pwm_r,
  output logic        pwm_g,
  output logic        pwm_b,
  output logic        frame_start
);

  localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

  logic [15:0] pre;
  logic [7:0]  ph;
  logic [7:0]  duty_r, duty_g, duty_b;
  logic        bnd_q;
  logic        tick, boundary;

  // (c * (brightness+1)) >> 8 keeps 255 unscaled and maps brightness 0 to off
  function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] br);
    logic [15:0] p;
    p = {8'd0, c} * ({8'd0, br} + 16'd1);
    return p[15:8];
  endfunction

  assign tick     = enable && (pre == PRE_MAX);
  assign boundary = tick && (ph == 8'd254);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre         <= '0;
      ph          <= '0;
      duty_r      <= '0;
      duty_g      <= '0;
      duty_b      <= '0;
      bnd_q       <= 1'b0;
      pwm_r       <= 1'b0;
      pwm_g       <= 1'b0;
      pwm_b       <= 1'b0;
      frame_start <= 1'b0;
    end else if (!enable) begin
      // Idle: track the inputs so the first enabled frame shows the current colour
      pre         <= '0;
      ph          <= '0;
      duty_r      <= scale(light[23:16], brightness);
      duty_g      <= scale(light[15:8], brightness);
      duty_b      <= scale(light[7:0], brightness);
      bnd_q       <= 1'b0;
      pwm_r       <= 1'b0;
      pwm_g       <= 1'b0;
      pwm_b       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pre <= tick ? 16'd0 : pre + 16'd1;
      if (tick) begin
        ph <= (ph == 8'd254) ? 8'd0 : ph + 8'd1;
      end
      if (boundary) begin
        duty_r <= scale(light[23:16], brightness);
        duty_g <= scale(light[15:8], brightness);
        duty_b <= scale(light[7:0], brightness);
      end
      // Outputs lag ph by one clock, so the pulse also waits one extra edge
      bnd_q       <= boundary;
      frame_start <= bnd_q;
      pwm_r       <= ph < duty_r;
      pwm_g       <= ph < duty_g;
      pwm_b       <= ph < duty_b;
    end
  end

endmodule
